dm_access_unit: RTL
===================

Name: dm_access_unit

Overview:
- Sequential data-memory access controller between the single-cycle core and a handshaked, word-wide, little-endian data memory.
- Turns core load/store requests into req/ack memory transactions and stalls the core until each transaction completes.
- Performs byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Drives the registered load value dm_out, which is the data-memory input of the writeback select mux.

Parameters:
- TIMEOUT, 255, ACCESS-state cycles without m_ack before the transaction is aborted (1..65535).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- cpu_rd  input  1  load request, held high until stall falls
- cpu_wr  input  1  store request, held high until stall falls; wins if asserted together with cpu_rd
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data, right-aligned
- cpu_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- cpu_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend
- stall  output  1  combinational: (cpu_rd|cpu_wr) & (state!=DONE)
- dm_out  output  32  registered load result, to the writeback mux data-memory input
- misalign_err  output  1  one-cycle pulse in DONE for a misaligned or reserved-size request
- timeout_err  output  1  one-cycle pulse in DONE for an aborted request
- m_req  output  1  memory request, registered
- m_we  output  1  1 = write
- m_addr  output  32  word address, {cpu_addr[31:2],2'b00}
- m_wdata  output  32  lane-replicated store data
- m_be  output  4  byte enables
- m_ack  input  1  memory completion, sampled only while m_req=1
- m_rdata  input  32  read data, valid with m_ack

Behaviour:
- Reset values: dm_out=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_be=0, misalign_err=0, timeout_err=0, timeout counter=0, state=IDLE. Reset is asynchronous.
- Reset mid-transaction: m_req drops immediately; no result is captured.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, request present, aligned:
  - Latch address, size, unsigned flag, byte-lane offset and write flag.
  - Drive m_req=1, m_we, m_addr, m_be, m_wdata.
  - Clear the timeout counter and go to ACCESS.
- IDLE, request present, misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 11):
  - No memory access; go to DONE with misalign_err=1.
  - dm_out keeps its previous value.
- ACCESS, m_ack=1:
  - Drop m_req and m_we.
  - For loads, register the extracted value into dm_out.
  - Go to DONE.
- ACCESS, m_ack=0:
  - Increment the counter.
  - When the counter equals TIMEOUT-1 and m_ack=0, drop m_req and go to DONE with timeout_err=1; dm_out is unchanged.
- DONE: stall=0 for exactly this cycle so the core retires the instruction. The error pulses are high only here. Next state is always IDLE.
- A request still high in IDLE after DONE is treated as a new instruction.
- Latency: zero-wait memory (ack in the first ACCESS cycle) gives 2 stall cycles plus the DONE cycle. In general, latency = ack wait + 2.
- Store lanes:
  - Byte: m_be=4'b0001<<addr[1:0]; m_wdata={4{wdata[7:0]}}.
  - Half: m_be=addr[1]?1100:0011; m_wdata={2{wdata[15:0]}}.
  - Word: m_be=1111; m_wdata=wdata.
- Loads: m_be=1111. Selected byte/half = m_rdata shifted right by 8*offset, then sign- or zero-extended to 32 bits.
- m_ack while m_req=0 is ignored.
- Write result: stores never modify dm_out.

Test Plan:
- Word load, addr 0x10, memory acks after 3 cycles with 0xDEADBEEF -> m_addr=0x10, m_be=1111; stall high 5 cycles then low 1; dm_out=0xDEADBEEF.
- Signed byte load, addr 0x13, rdata 0x80112233 -> dm_out=0xFFFFFF80. Repeat with cpu_unsigned=1 -> dm_out=0x00000080.
- Half store, addr 0x22, wdata 0x0000ABCD -> m_we=1, m_addr=0x20, m_be=1100, m_wdata=0xABCDABCD; dm_out unchanged.
- Word load at addr 0x06 -> no m_req; misalign_err single pulse; stall high 1 cycle; dm_out unchanged. Same response for size 11 at any address.
- TIMEOUT=4, m_ack never asserted -> m_req high exactly 4 cycles; timeout_err pulse in DONE; dm_out unchanged. Next request proceeds normally.
- rst_n low while in ACCESS -> m_req and dm_out are 0 immediately. A late m_ack after reset is ignored. cpu_rd and cpu_wr together -> store performed.

Source files
------------

// File: rtl/dm_access_unit.sv
// dm_access_unit: data-memory access controller between the core and a
// req/ack word-wide little-endian memory. Stalls the core for the duration of
// each transaction, steers store bytes onto lanes, and extracts and extends
// load data into the registered dm_out.
module dm_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    output logic        stall,
    output logic [31:0] dm_out,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic        m_ack,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0]  SZ_BYTE  = 2'b00;
    localparam logic [1:0]  SZ_HALF  = 2'b01;
    localparam logic [1:0]  SZ_WORD  = 2'b10;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] tmo_cnt;
    logic [1:0]  lat_size;
    logic [1:0]  lat_off;
    logic        lat_uns;
    logic        lat_wr;

    logic        req_any;
    logic        misaligned;
    logic        acked;
    logic        expired;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_shift;
    logic [31:0] ld_val;

    assign req_any = cpu_rd | cpu_wr;
    assign stall   = req_any & (state != DONE);
    // m_ack only counts while a request is outstanding.
    assign acked   = (state == ACCESS) & m_req & m_ack;
    assign expired = (state == ACCESS) & ~m_ack & (tmo_cnt == TMO_LAST);

    // Alignment check: reserved size, odd halfword or non-word-aligned word.
    always_comb begin
        misaligned = 1'b0;
        case (cpu_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = cpu_addr[0];
            SZ_WORD: misaligned = (cpu_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process ordering.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_nx = state;
        case (state)
            IDLE:    if (req_any) state_nx = misaligned ? DONE : ACCESS;
            ACCESS:  if (acked || expired) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Store lane steering: replicate the datum across the word, enable its lanes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = cpu_wdata;
        case (cpu_size)
            SZ_BYTE: begin
                st_be    = 4'b0001 << cpu_addr[1:0];
                st_wdata = {4{cpu_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{cpu_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        ld_shift = m_rdata >> {lat_off, 3'b000};
        ld_val   = ld_shift;
        case (lat_size)
            SZ_BYTE: ld_val = {{24{~lat_uns & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_val = {{16{~lat_uns & ld_shift[15]}}, ld_shift[15:0]};
            default: ;
        endcase
    end

    // Memory interface, transaction context, timeout counter, result and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_out       <= '0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            m_be         <= '0;
            tmo_cnt      <= '0;
            lat_size     <= '0;
            lat_off      <= '0;
            lat_uns      <= 1'b0;
            lat_wr       <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (misaligned) begin
                            misalign_err <= 1'b1;
                        end else begin
                            lat_size <= cpu_size;
                            lat_off  <= cpu_addr[1:0];
                            lat_uns  <= cpu_unsigned;
                            lat_wr   <= cpu_wr;
                            m_req    <= 1'b1;
                            m_we     <= cpu_wr;
                            m_addr   <= {cpu_addr[31:2], 2'b00};
                            m_be     <= cpu_wr ? st_be : 4'b1111;
                            if (cpu_wr) m_wdata <= st_wdata;
                            tmo_cnt  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (acked) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        if (!lat_wr) dm_out <= ld_val;
                    end else if (expired) begin
                        m_req       <= 1'b0;
                        m_we        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
